// File: rtl/puf_uart_ctrl.sv
// Command sequencer between the UART byte interface and the PUF core.
// Optional PUF_UART_CTRL_TIMEOUT_EN adds a WAIT_DONE timeout that answers with a NAK byte.
module puf_uart_ctrl #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned CHAL_BYTES     = 8,
  parameter int unsigned RESP_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [DATA_BITS-1:0]            rx_data,
  input  logic                            rx_valid,
  output logic                            rx_enable,
  output logic [DATA_BITS-1:0]            tx_data,
  output logic                            tx_enable,
  input  logic                            tx_busy,
  output logic [DATA_BITS*CHAL_BYTES-1:0] puf_challenge,
  output logic                            puf_start,
  input  logic                            puf_done,
  input  logic [DATA_BITS*RESP_BYTES-1:0] puf_response,
  output logic                            busy,
  output logic                            error
);

  localparam int unsigned CW    = DATA_BITS * CHAL_BYTES;
  localparam int unsigned RW    = DATA_BITS * RESP_BYTES;
  localparam int unsigned QW    = RW + DATA_BITS;
  localparam int unsigned CNT_W = 5;

  localparam logic [DATA_BITS-1:0] CMD_START = DATA_BITS'(8'hA5);
  localparam logic [DATA_BITS-1:0] RSP_HDR   = DATA_BITS'(8'h5A);
  localparam logic [DATA_BITS-1:0] RSP_NAK   = DATA_BITS'(8'hEE);

  localparam logic [CNT_W-1:0] CHAL_LAST = CNT_W'(CHAL_BYTES - 1);
  localparam logic [CNT_W-1:0] RSP_TOTAL = CNT_W'(RESP_BYTES + 1);

  if (DATA_BITS != 8 || CHAL_BYTES == 0 || CHAL_BYTES > 16 ||
      RESP_BYTES == 0 || RESP_BYTES > 16 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("puf_uart_ctrl: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, RX_CHAL, START, WAIT_DONE, TX_LOAD, TX_PULSE, TX_GAP, TX_WAIT
  } state_t;

  state_t           state;
  logic [CW-1:0]    chal_sr;
  logic [QW-1:0]    tx_q;
  logic [CNT_W-1:0] byte_idx;
  logic [CNT_W-1:0] tx_total;
`ifdef PUF_UART_CTRL_TIMEOUT_EN
  logic [31:0]      tmo_cnt;
`endif

  // Sequencer; challenge is assembled in chal_sr so puf_challenge only updates when a frame completes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      rx_enable     <= 1'b0;
      tx_data       <= '0;
      tx_enable     <= 1'b0;
      puf_challenge <= '0;
      puf_start     <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      chal_sr       <= '0;
      tx_q          <= '0;
      byte_idx      <= '0;
      tx_total      <= '0;
`ifdef PUF_UART_CTRL_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      puf_start <= 1'b0;
      tx_enable <= 1'b0;
      case (state)
        IDLE: begin
          rx_enable <= 1'b1;
          if (rx_valid) begin
            busy     <= 1'b1;
            byte_idx <= '0;
            if (rx_data == CMD_START) begin
              error <= 1'b0;
              state <= RX_CHAL;
            end else begin
              error     <= 1'b1;
              rx_enable <= 1'b0;
              tx_q      <= {RSP_NAK, RW'(0)};
              tx_total  <= CNT_W'(1);
              state     <= TX_LOAD;
            end
          end
        end
        RX_CHAL: begin
          if (rx_valid) begin
            chal_sr <= (chal_sr << DATA_BITS) | CW'(rx_data);
            if (byte_idx == CHAL_LAST) begin
              puf_challenge <= (chal_sr << DATA_BITS) | CW'(rx_data);
              puf_start     <= 1'b1;
              rx_enable     <= 1'b0;
              byte_idx      <= '0;
`ifdef PUF_UART_CTRL_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
              state         <= START;
            end else begin
              byte_idx <= byte_idx + CNT_W'(1);
            end
          end
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (puf_done) begin
            tx_q     <= {RSP_HDR, puf_response};
            tx_total <= RSP_TOTAL;
            state    <= TX_LOAD;
          end
`ifdef PUF_UART_CTRL_TIMEOUT_EN
          else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            error    <= 1'b1;
            tx_q     <= {RSP_NAK, RW'(0)};
            tx_total <= CNT_W'(1);
            state    <= TX_LOAD;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
`endif
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_data   <= tx_q[QW-1 -: DATA_BITS];
            tx_q      <= tx_q << DATA_BITS;
            byte_idx  <= byte_idx + CNT_W'(1);
            tx_enable <= 1'b1;
            state     <= TX_PULSE;
          end
        end
        TX_PULSE: state <= TX_GAP;
        TX_GAP:   state <= TX_WAIT;
        TX_WAIT: begin
          if (!tx_busy) begin
            if (byte_idx != tx_total) begin
              state <= TX_LOAD;
            end else begin
              busy      <= 1'b0;
              rx_enable <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_uart_ctrl.sv
// Scoreboard bench for puf_uart_ctrl: UART TX busy model, PUF stub driven from the main thread.
module tb_puf_uart_ctrl;

  localparam int unsigned FRAME = 12;

  logic        clk;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_enable;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_busy;
  logic [63:0] puf_challenge;
  logic        puf_start;
  logic        puf_done;
  logic [31:0] puf_response;
  logic        busy;
  logic        error;

  logic        hold_busy;
  int unsigned busy_cnt;
  int          n_vec;
  int          n_bad;
  int          n_start;
  logic [7:0]  sb[$];

  puf_uart_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_enable    (rx_enable),
    .tx_data      (tx_data),
    .tx_enable    (tx_enable),
    .tx_busy      (tx_busy),
    .puf_challenge(puf_challenge),
    .puf_start    (puf_start),
    .puf_done     (puf_done),
    .puf_response (puf_response),
    .busy         (busy),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // UART transmitter: busy for FRAME cycles after each send strobe
  always @(posedge clk or negedge resetn) begin
    if (!resetn)             busy_cnt <= 0;
    else if (tx_enable)      busy_cnt <= FRAME;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy | (busy_cnt != 0);

  always @(posedge clk) if (resetn && puf_start) n_start++;

  // Every transmitted byte must be expected and sent only while the UART is idle
  always @(negedge clk) begin
    if (resetn && tx_enable) begin
      check_eq("tx_while_busy", 64'(tx_busy), 64'd0);
      check_eq("tx_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check_eq("tx_byte", 64'(tx_data), 64'(sb.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (puf_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("puf_start_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check_eq("busy_falls", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rx_enable"}, 64'(rx_enable), 64'd0);
    check_eq({tag, "_tx_enable"}, 64'(tx_enable), 64'd0);
    check_eq({tag, "_tx_data"},   64'(tx_data),   64'd0);
    check_eq({tag, "_puf_start"}, 64'(puf_start), 64'd0);
    check_eq({tag, "_challenge"}, puf_challenge,  64'd0);
    check_eq({tag, "_busy"},      64'(busy),      64'd0);
    check_eq({tag, "_error"},     64'(error),     64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 resetn = 1'b0;
    #1 check_reset_vals(tag);
    sb.delete();
    hold_busy = 1'b0;
    puf_done  = 1'b0;
    rx_valid  = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rx_enable_back"}, 64'(rx_enable), 64'd1);
  endtask

  // mode: 0 plain, 1 inject A5 bytes while busy, 2 slow transmitter, 3 reset during TX_WAIT
  task automatic do_frame(input logic [63:0] chal, input logic [31:0] resp, input int mode);
    bit ok;
    int s0;
    s0 = n_start;
    send_byte(8'hA5);
    check_eq("err_clear_on_a5", 64'(error), 64'd0);
    for (int i = 0; i < 8; i++) send_byte(chal[63-8*i -: 8]);
    wait_start(ok);
    if (ok) check_eq("challenge", puf_challenge, chal);
    check_eq("rx_en_after_chal", 64'(rx_enable), 64'd0);
    if (mode == 1) begin
      send_byte(8'hA5);
      check_eq("rx_en_wait_done", 64'(rx_enable), 64'd0);
      repeat (8) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    if (mode == 2) hold_busy = 1'b1;
    puf_response = resp;
    puf_done     = 1'b1;
    sb.push_back(8'h5A);
    for (int i = 0; i < 4; i++) sb.push_back(resp[31-8*i -: 8]);
    @(negedge clk);
    puf_done = 1'b0;
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      send_byte(8'hA5);
      check_eq("rx_en_tx", 64'(rx_enable), 64'd0);
    end
    if (mode == 2) begin
      repeat (50) @(negedge clk);
      check_eq("slow_queue_intact", 64'(sb.size()), 64'd5);
      hold_busy = 1'b0;
    end
    if (mode == 3) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (tx_enable) begin
          ok = 1'b1;
          break;
        end
      end
      check_eq("first_tx_seen", 64'(ok), 64'd1);
      repeat (3) @(negedge clk);
      pulse_reset("rst_tx");
    end else begin
      wait_idle();
      check_eq("sb_drained", 64'(sb.size()), 64'd0);
      check_eq("one_start", 64'(n_start - s0), 64'd1);
      check_eq("rx_en_idle", 64'(rx_enable), 64'd1);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s0;
    n_vec = 0; n_bad = 0; n_start = 0;
    resetn = 1'b0; rx_data = '0; rx_valid = 1'b0;
    puf_done = 1'b0; puf_response = '0; hold_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rx_en_after_reset", 64'(rx_enable), 64'd1);

    do_frame(64'h0102030405060708, 32'hDEADBEEF, 0);

    s0 = n_start;
    sb.push_back(8'hEE);
    send_byte(8'h3C);
    check_eq("bad_cmd_error", 64'(error), 64'd1);
    check_eq("bad_cmd_busy",  64'(busy),  64'd1);
    wait_idle();
    check_eq("nak_drained", 64'(sb.size()), 64'd0);
    check_eq("nak_no_start", 64'(n_start - s0), 64'd0);
    check_eq("error_sticky", 64'(error), 64'd1);
    do_frame(64'h1122334455667788, 32'h01234567, 0);

    do_frame(64'hA5A5A5A5C3C3C3C3, 32'h89ABCDEF, 1);

    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i));
    pulse_reset("rst_chal");
    do_frame(64'hFEDCBA9876543210, 32'hCAFEF00D, 0);

    do_frame(64'h0F1E2D3C4B5A6978, 32'h5AA5EE11, 3);
    do_frame(64'h0102030405060708, 32'hDEADBEEF, 0);

    do_frame(64'h8877665544332211, 32'h00FF7F80, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/puf_uart_ctrl.md
# puf_uart_ctrl

Command sequencer between the `uart` byte interface and the PUF core. It collects a challenge frame from the UART receiver and pulses the PUF to evaluate it. It then serialises the PUF response back through the UART transmitter, one byte per `tx_enable`/`tx_busy` handshake. It is the only block that drives the UART TX/RX enables and the PUF start strobe.

## Interface
- `DATA_BITS`, 8: UART payload width; fixed at 8 for this protocol.
- `CHAL_BYTES`, 8: challenge length in bytes (1..16).
- `RESP_BYTES`, 4: response length in bytes (1..16).
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles to wait for `puf_done` (only with macro).

- `clk` in 1: system clock, 100 MHz.
- `resetn` in 1: asynchronous active-low reset.
- `rx_data` in 8: received byte from the UART.
- `rx_valid` in 1: one-cycle pulse when `rx_data` is valid.
- `rx_enable` out 1: enables UART reception.
- `tx_data` out 8: byte to transmit.
- `tx_enable` out 1: one-cycle send strobe.
- `tx_busy` in 1: UART transmitter busy.
- `puf_challenge` out 8*CHAL_BYTES: challenge word driven to the PUF.
- `puf_start` out 1: one-cycle evaluate strobe.
- `puf_done` in 1: PUF result valid; level or pulse.
- `puf_response` in 8*RESP_BYTES: PUF result.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: sticky; set on a bad command or timeout, cleared when a valid command byte is accepted.

## Operation
- FSM states: IDLE, RX_CHAL, START, WAIT_DONE, TX_LOAD, TX_PULSE, TX_GAP, TX_WAIT.
- **IDLE**
  - `rx_enable`=1.
  - On `rx_valid` with `rx_data`=0xA5: clear `error`, byte counter=0, go to RX_CHAL.
  - On `rx_valid` with any other byte: set `error`, queue the single byte 0xEE (NAK), go to TX_LOAD.
- **RX_CHAL**
  - `rx_enable`=1.
  - Each `rx_valid` shifts the byte into `puf_challenge` from the LSB end, so the first byte ends up in bits [8*CHAL_BYTES-1 -: 8].
  - After the CHAL_BYTES-th byte, go to START.
- **START**
  - `rx_enable`=0 from here until the return to IDLE; bytes arriving meanwhile are lost.
  - `puf_start`=1 for exactly this cycle, then go to WAIT_DONE.
- **WAIT_DONE**
  - On `puf_done`=1: latch `puf_response`, queue the header 0x5A followed by RESP_BYTES response bytes, MSB byte first.
  - Then go to TX_LOAD.
- **TX_LOAD**: when `tx_busy`=0, drive the next queued byte on `tx_data` and go to TX_PULSE.
- **TX_PULSE**: `tx_enable`=1 for one cycle, `tx_data` held; go to TX_GAP.
- **TX_GAP**: one dead cycle so `tx_busy` can rise; go to TX_WAIT.
- **TX_WAIT**: when `tx_busy`=0, go to TX_LOAD if bytes remain, else to IDLE.
- Counters:
  - Byte index is 5 bits; the queue holds at most 17 bytes.
  - Terminal counts are compared exactly; a counter never wraps in normal operation.
- `puf_challenge` holds its value from START until the next 0xA5 frame completes.

## Timing
- Reset values:
  - FSM=IDLE, `rx_enable`=0 during reset then 1 from the first clock after release.
  - `tx_enable`=0, `tx_data`=0x00.
  - `puf_start`=0, `puf_challenge`=0.
  - `busy`=0, `error`=0.
- All outputs are registered.
- Last challenge byte `rx_valid` at cycle t: `puf_start`=1 at t+1. `puf_done` is sampled from t+2 onward; a `puf_done` coincident with `puf_start` is ignored.
- `puf_done` at cycle d: TX_LOAD at d+1. The first `tx_enable` is at d+2 if `tx_busy`=0.
- Byte-to-byte spacing is the UART frame time plus 3 cycles minimum.
- `rx_valid` arriving in START/WAIT_DONE/TX_* is ignored.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. A UART frame in flight is not tracked.

## Configuration
- `PUF_UART_CTRL_TIMEOUT_EN` defined:
  - A 32-bit cycle counter runs in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without `puf_done`: set `error`, queue 0xEE, go to TX_LOAD.
  - The counter clears on entry to START.
- `PUF_UART_CTRL_TIMEOUT_EN` undefined:
  - No counter is synthesised and the `TIMEOUT_CYCLES` parameter is unused.
  - WAIT_DONE waits indefinitely for `puf_done` (exit only via reset).

## Test plan
- **Nominal frame**: send A5 01 02 03 04 05 06 07 08; `puf_done` 10 cycles after `puf_start` with `puf_response`=0xDEADBEEF.
  - One `puf_start` pulse and `puf_challenge`=0x0102030405060708.
  - TX bytes 5A DE AD BE EF, each `tx_enable` issued only while `tx_busy`=0; `busy` falls after the last byte.
- **Bad command**: send 0x3C.
  - `error`=1 and TX byte EE; no `puf_start`.
  - Follow with a valid A5 frame: `error` clears on the A5.
- **Timeout** (macro on, TIMEOUT_CYCLES=100): valid frame, `puf_done` never asserted.
  - TX EE at 100 cycles after WAIT_DONE entry; `error`=1; back to IDLE.
- **Ignored input**: extra `rx_valid` bytes 0xA5 injected during WAIT_DONE and during TX.
  - No effect on the response; `rx_enable`=0 throughout.
- **Reset mid-operation**: `resetn` low during RX_CHAL after 3 bytes, and again during TX_WAIT.
  - All outputs return to reset values asynchronously.
  - A fresh full frame afterwards yields the correct response.
- **Slow transmitter**: `tx_busy` held high for 50 cycles before the first byte.
  - `tx_enable` is withheld until `tx_busy` falls; no byte is lost or duplicated.
